// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server
//   Hands out pseudo-random words from one shared 16-bit XNOR LFSR to up to
//   N_REQ requesters. The LFSR steps only when a word is granted, so every
//   granted word is the next value in the sequence and no value is skipped.
//   After reset or reseed the LFSR first free-runs WARMUP steps to move away
//   from the seed.
//
//   Grant timing: in IDLE the round-robin winner is latched and the LFSR
//   steps. The next edge (GRANT) registers ack/rnd_out/rnd_id, so ack is
//   visible for one cycle, two edges after req was first seen.
//
//   Handshake: req_i[i] is a level held until ack_o[i] pulses for one cycle.
//   The requester drops req the cycle after ack. During the ack cycle the
//   acked requester's own req is ignored. If it is still high one cycle
//   later, it counts as a new request.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   seed_i     value loaded on reseed (0xFFFF is replaced by 0x0001)
//   reseed_i   synchronous pulse: load seed_i, restart warm-up
//   req_i      per-requester request levels
//   ack_o      one-hot, single-cycle grant pulse
//   rnd_out_o  granted word, meaningful only while ack_o != 0
//   rnd_id_o   index of the acked requester, meaningful with ack_o
//   busy_o     high while warming up
module lfsr_rr_server #(
  parameter int          N_REQ      = 4,
  parameter int          WARMUP     = 16,
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              seed_i,
  input  logic                     reseed_i,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         ack_o,
  output logic [15:0]              rnd_out_o,
  output logic [$clog2(N_REQ)-1:0] rnd_id_o,
  output logic                     busy_o
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam logic [CW-1:0] WU_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic          WU_BUSY = (WARMUP > 0);

  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_IDLE   = 2'd1,
    S_GRANT  = 2'd2
  } state_t;

  localparam state_t INIT_STATE = (WARMUP > 0) ? S_WARMUP : S_IDLE;

  // All-ones is the only lock-up state of the XNOR form.
  function automatic logic [15:0] lock_safe(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'h0001 : v;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ~(v[15] ^ v[14] ^ v[12] ^ v[3])};
  endfunction

  localparam logic [15:0] RESET_LFSR = lock_safe(RESET_SEED);

  state_t           state_q;
  logic [15:0]      lfsr_q;
  logic [CW-1:0]    cnt_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   win_q;
  logic [N_REQ-1:0] ack_q;
  logic [15:0]      rnd_q;
  logic [IDW-1:0]   id_q;
  logic             busy_q;

  logic [N_REQ-1:0] eff_req;
  logic             arb_valid;
  logic [IDW-1:0]   arb_win;

  // Round robin: first request at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    arb_valid = 1'b0;
    arb_win   = '0;
    eff_req   = req_i & ~ack_q;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!arb_valid && eff_req[idx]) begin
        arb_valid = 1'b1;
        arb_win   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_STATE;
      lfsr_q  <= RESET_LFSR;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      ack_q   <= '0;
      rnd_q   <= '0;
      id_q    <= '0;
      busy_q  <= WU_BUSY;
    end else begin
      ack_q <= '0;
      if (reseed_i) begin
        // Takes priority in every state; a grant in flight is dropped and
        // the pointer keeps its value.
        lfsr_q  <= lock_safe(seed_i);
        cnt_q   <= '0;
        state_q <= INIT_STATE;
        busy_q  <= WU_BUSY;
      end else begin
        case (state_q)
          S_WARMUP: begin
            lfsr_q <= lfsr_step(lfsr_q);
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == WU_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          S_IDLE: begin
            if (arb_valid) begin
              lfsr_q  <= lfsr_step(lfsr_q);
              win_q   <= arb_win;
              state_q <= S_GRANT;
            end
          end
          S_GRANT: begin
            ack_q   <= N_REQ'(1) << win_q;
            rnd_q   <= lfsr_q;
            id_q    <= win_q;
            ptr_q   <= (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ack_o     = ack_q;
  assign rnd_out_o = rnd_q;
  assign rnd_id_o  = id_q;
  assign busy_o    = busy_q;

endmodule
